// File: rtl/v_multipliers_6_inv.sv
// v_multipliers_6_inv: recovers A from RES = add_sub ? C + A*B : C - A*B.
// Forms D = add_sub ? RES - C : C - RES (mod 2^(2W)) and divides D by B with a
// one-bit-per-cycle restoring divider behind a start/done handshake.
// Optional macro DIVINV_INPUT_REG_EN adds one register stage on all inputs.
module v_multipliers_6_inv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               add_sub,
  input  logic [2*WIDTH-1:0] RES,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   A_OUT,
  output logic [WIDTH-1:0]   REM,
  output logic               exact,
  output logic               ovf,
  output logic               div0
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Input view used by the control logic (direct or registered)
  logic             start_s;
  logic             add_sub_s;
  logic [DW-1:0]    res_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] c_s;

`ifdef DIVINV_INPUT_REG_EN
  // Optional input register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s   <= 1'b0;
      add_sub_s <= 1'b0;
      res_s     <= '0;
      b_s       <= '0;
      c_s       <= '0;
    end else begin
      start_s   <= start;
      add_sub_s <= add_sub;
      res_s     <= RES;
      b_s       <= B;
      c_s       <= C;
    end
  end
`else
  assign start_s   = start;
  assign add_sub_s = add_sub;
  assign res_s     = RES;
  assign b_s       = B;
  assign c_s       = C;
`endif

  state_t           state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [DW-1:0]    q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exact_q, exact_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;

  logic [DW-1:0]    d_in;
  logic [WIDTH:0]   shift_r;
  logic [WIDTH:0]   sub_r;
  logic             q_hi;

  // Dividend: wraps modulo 2^(2W), C zero-extended
  assign d_in = add_sub_s ? (res_s - DW'(c_s)) : (DW'(c_s) - res_s);

  // Partial remainder step: bring in the next dividend bit and trial-subtract B
  assign shift_r = {r_q[WIDTH-1:0], d_q[DW-1]};
  assign sub_r   = shift_r - {1'b0, b_q};
  assign q_hi    = |q_q[DW-1:WIDTH];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      rem_q   <= '0;
      exact_q <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  // Next-state, iteration and result logic
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_d     = a_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          b_d     = b_s;
          d_d     = d_in;
          q_d     = '0;
          r_d     = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
          // Divide by zero skips the iteration loop and resolves next edge
          cnt_d   = (b_s == '0) ? CW'(DW) : '0;
        end
      end

      S_CALC: begin
        if (cnt_q == CW'(DW)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (b_q == '0) begin
            div0_d  = 1'b1;
            ovf_d   = 1'b0;
            exact_d = 1'b0;
            a_d     = '1;
            rem_d   = '0;
          end else begin
            div0_d  = 1'b0;
            ovf_d   = q_hi;
            exact_d = !q_hi && (r_q == '0);
            a_d     = q_hi ? '1 : q_q[WIDTH-1:0];
            rem_d   = r_q[WIDTH-1:0];
          end
        end else begin
          d_d   = {d_q[DW-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (shift_r >= {1'b0, b_q}) begin
            r_d = sub_r;
            q_d = {q_q[DW-2:0], 1'b1};
          end else begin
            r_d = shift_r;
            q_d = {q_q[DW-2:0], 1'b0};
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign A_OUT = a_q;
  assign REM   = rem_q;
  assign exact = exact_q;
  assign ovf   = ovf_q;
  assign div0  = div0_q;

endmodule
